// File: rtl/div_pkg.sv
// Shared types and constants for the 8-by-4 unsigned sequential divider.
package div_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int ITER       = 8;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division stage: shift in the next dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W-1:0] r,
  input  logic                 msb,
  input  logic [DIVISOR_W-1:0] d,
  output logic [DIVISOR_W-1:0] r_next,
  output logic                 qbit
);

  logic [DIVISOR_W:0]   w_t;
  logic [DIVISOR_W-1:0] w_diff;

  assign w_t = {r, msb};
  // Only the low bits of the difference survive, since t - d < d whenever it is taken.
  assign w_diff = w_t[DIVISOR_W-1:0] - d;
  assign qbit   = (w_t >= {1'b0, d});
  assign r_next = qbit ? w_diff : w_t[DIVISOR_W-1:0];

endmodule

// File: rtl/div8u4_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, behind
// valid/ready request and response handshakes.
module div8u4_seq
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  state_t                r_state;
  logic [DIVIDEND_W-1:0] r_q;
  logic [DIVISOR_W-1:0]  r_r;
  logic [DIVISOR_W-1:0]  r_d;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_dbz;
  logic [DIVIDEND_W-1:0] r_quot;
  logic [DIVISOR_W-1:0]  r_rem;
  logic                  r_dbzOut;

  logic [DIVISOR_W-1:0]  w_rNext;
  logic                  w_qbit;
  logic [DIVIDEND_W-1:0] w_qNext;

  div_step u_step (
    .r      (r_r),
    .msb    (r_q[DIVIDEND_W-1]),
    .d      (r_d),
    .r_next (w_rNext),
    .qbit   (w_qbit)
  );

  assign w_qNext     = {r_q[DIVIDEND_W-2:0], w_qbit};
  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbzOut;

  // Divisor 0 runs the normal algorithm; the flag is purely informational.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_r      <= '0;
      r_d      <= '0;
      r_cnt    <= '0;
      r_dbz    <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dbzOut <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_q     <= dividend;
            r_d     <= divisor;
            r_r     <= '0;
            r_cnt   <= '0;
            r_dbz   <= (divisor == '0);
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_q   <= w_qNext;
          r_r   <= w_rNext;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == CNT_W'(ITER - 1)) begin
            r_quot   <= w_qNext;
            r_rem    <= w_rNext;
            r_dbzOut <= r_dbz;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div8u4_seq.sv
// Self-checking bench for div8u4_seq: directed scenarios plus an exhaustive
// sweep, with expected results queued at acceptance and checked at handshake.
module tb_div8u4_seq;

  typedef struct packed {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
  } result_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [3:0] divisor = 4'd0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  result_t expQ[$];
  int      checks = 0;
  int      errors = 0;
  bit      randReady = 1'b0;

  div8u4_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (randReady) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  function automatic result_t refModel(input logic [7:0] a, input logic [3:0] b);
    result_t    res;
    logic [7:0] m;
    res.a = a;
    res.b = b;
    if (b == 4'd0) begin
      res.q   = 8'hFF;
      res.r   = a[3:0];
      res.dbz = 1'b1;
    end else begin
      res.q   = a / {4'd0, b};
      m       = a % {4'd0, b};
      res.r   = m[3:0];
      res.dbz = 1'b0;
    end
    return res;
  endfunction

  task automatic applyStimulus(input logic [7:0] a, input logic [3:0] b,
                               input logic [7:0] q, input logic [3:0] r,
                               input logic dbz, input bit holdValid);
    bit      accepted = 1'b0;
    result_t e;
    e.a = a; e.b = b; e.q = q; e.r = r; e.dbz = dbz;
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    for (int n = 0; n < 200 && !accepted; n++) begin
      if (in_ready) begin
        expQ.push_back(e);
        accepted = 1'b1;
      end
      tick();
    end
    checkOutput($sformatf("accept %0d/%0d", a, b), 32'(accepted), 32'd1);
    if (!holdValid) in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit idle = 1'b0;
    for (int n = 0; n < 500 && !idle; n++) begin
      if (expQ.size() == 0 && in_ready) idle = 1'b1;
      else tick();
    end
    checkOutput("drain_timeout", 32'(idle), 32'd1);
  endtask

  // Response monitor: compares each handshaken result with the head of the queue.
  always @(negedge clk) begin : monitor
    result_t e;
    if (rst_n && out_valid && out_ready) begin
      checkOutput("result_expected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput($sformatf("quotient %0d/%0d", e.a, e.b), 32'(quotient), 32'(e.q));
        checkOutput($sformatf("remainder %0d/%0d", e.a, e.b), 32'(remainder), 32'(e.r));
        checkOutput($sformatf("div_by_zero %0d/%0d", e.a, e.b), 32'(div_by_zero), 32'(e.dbz));
      end
    end
  end

  initial begin
    #900_000;
    errors++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int      lat;
    bit      early;
    bit      sawValid;
    result_t m;

    // Reset
    #2 rst_n = 1'b0;
    #10;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset quotient", 32'(quotient), 32'd0);
    checkOutput("reset remainder", 32'(remainder), 32'd0);
    checkOutput("reset div_by_zero", 32'(div_by_zero), 32'd0);

    // 225 / 15: latency and in_ready window
    applyStimulus(8'd225, 4'd15, 8'd15, 4'd0, 1'b0, 1'b0);
    lat = 0;
    early = 1'b0;
    while (!out_valid && lat < 50) begin
      if (in_ready) early = 1'b1;
      tick();
      lat++;
    end
    checkOutput("latency_to_out_valid", 32'(lat), 32'd8);
    while (!in_ready && lat < 60) begin
      tick();
      lat++;
    end
    checkOutput("in_ready_low_cycles", 32'(lat), 32'd9);
    checkOutput("in_ready_early", 32'(early), 32'd0);

    // Back-to-back with in_valid held; operand changes during BUSY are ignored
    applyStimulus(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1'b1);
    applyStimulus(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 1'b1);
    applyStimulus(8'd0, 4'd9, 8'd0, 4'd0, 1'b0, 1'b0);
    waitIdle();

    // Divide by zero, then a normal request clears the flag
    applyStimulus(8'hAB, 4'd0, 8'hFF, 4'hB, 1'b1, 1'b0);
    applyStimulus(8'h40, 4'd4, 8'd16, 4'd0, 1'b0, 1'b0);
    waitIdle();

    // Consumer stall holds DONE with frozen outputs
    out_ready = 1'b0;
    applyStimulus(8'd150, 4'd11, 8'd13, 4'd7, 1'b0, 1'b0);
    for (int n = 0; n < 50 && !out_valid; n++) tick();
    checkOutput("stall reach_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall out_valid c%0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("stall quotient c%0d", i), 32'(quotient), 32'd13);
      checkOutput($sformatf("stall remainder c%0d", i), 32'(remainder), 32'd7);
      tick();
    end
    out_ready = 1'b1;
    tick();
    checkOutput("idle_after_ready in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_after_ready out_valid", 32'(out_valid), 32'd0);
    waitIdle();

    // Reset during iteration 4 of 99 / 5 aborts the operation
    applyStimulus(8'd99, 4'd5, 8'd19, 4'd4, 1'b0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("abort out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd1);
    checkOutput("abort quotient", 32'(quotient), 32'd0);
    checkOutput("abort remainder", 32'(remainder), 32'd0);
    checkOutput("abort div_by_zero", 32'(div_by_zero), 32'd0);
    tick();
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) sawValid = 1'b1;
      tick();
    end
    checkOutput("abort no_out_valid", 32'(sawValid), 32'd0);
    applyStimulus(8'd99, 4'd5, 8'd19, 4'd4, 1'b0, 1'b0);
    waitIdle();

    // Exhaustive sweep with random consumer stalls
    randReady = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        m = refModel(8'(a), 4'(b));
        applyStimulus(8'(a), 4'(b), m.q, m.r, m.dbz, 1'b0);
      end
    end

    // Multiplier round trip: (a*b)/b == a remainder 0
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        applyStimulus(8'(a * b), 4'(b), 8'(a), 4'd0, 1'b0, 1'b0);
      end
    end
    waitIdle();
    randReady = 1'b0;
    out_ready = 1'b1;

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div8u4_seq.md
# div8u4_seq

Sequential unsigned restoring divider: 8-bit dividend by 4-bit divisor, producing an 8-bit quotient and 4-bit remainder, one quotient bit per clock. It is the inverse-direction companion of the 4x4 unsigned exact multipliers. Its 8-bit dividend matches their product width, so for any b ≠ 0, dividing a·b by b returns a with remainder 0. The block sits behind a valid/ready request interface and presents its result on a valid/ready response interface.

## Interface
- No parameters. Widths are fixed: 8-bit dividend and quotient, 4-bit divisor and remainder, matching the 4x4 multiplier product and operand widths.
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request; high only in IDLE
- dividend  in  8  unsigned dividend; sampled only on acceptance
- divisor  in  4  unsigned divisor; sampled only on acceptance
- out_valid  out  1  result valid; high only in DONE
- out_ready  in  1  consumer accepts the result
- quotient  out  8  registered quotient
- remainder  out  4  registered remainder
- div_by_zero  out  1  registered flag, set when the accepted divisor was 0

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: 8 iterations.
  - DONE: out_valid=1.
- Transitions:
  - IDLE→BUSY on in_valid&in_ready. Load q←dividend, d←divisor, r←0, cnt←0, dbz←(divisor==0).
  - BUSY: each cycle computes t={r[3:0],q[7]} (5 bits).
    - If t≥{1'b0,d}: r←t−d and the new q LSB is 1.
    - Otherwise: r←t and the new q LSB is 0.
    - Then q←{q[6:0],bit} and cnt←cnt+1.
  - BUSY→DONE on the iteration where cnt==7. In the same edge: quotient←final q, remainder←final r[3:0], div_by_zero←dbz.
  - DONE→IDLE on out_valid&out_ready. In that cycle in_ready stays 0, so back-to-back accept in that cycle is impossible.
- Divisor 0 follows the same algorithm with no special path. The result is quotient=8'hFF, remainder=dividend[3:0], div_by_zero=1, at the normal latency.
- Changes on dividend/divisor after acceptance are ignored.
- quotient, remainder and div_by_zero hold their last values through IDLE and BUSY until the next DONE entry. They are stable for the whole time out_valid is high.
- Remainder is always < divisor when divisor ≠ 0. r never exceeds 5 bits.

## Timing
- Reset (async assert, any state): state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, internal q/r/d/cnt=0.
- Reset mid-BUSY or mid-DONE aborts the operation and no out_valid is produced.
- Acceptance at edge k. Iterations occur at edges k+1…k+8. out_valid is high from edge k+8 until the handshake edge m. in_ready returns high after edge m.
- Minimum request-to-request period: 10 cycles (accept, 8 iterations, 1 DONE cycle with immediate out_ready).
- out_ready low holds DONE indefinitely with outputs frozen.
- out_ready while not in DONE is ignored.

## Structure
- Shared package div_pkg holds:
  - state enum {IDLE, BUSY, DONE}
  - DIVIDEND_W=8, DIVISOR_W=4, ITER=8 constants
  - counter width (3 bits)
- One combinational sub-module, div_step: inputs r[3:0], msb and d[3:0]; outputs r_next[3:0] and qbit. It is the single conditional-subtract stage, instanced once and reused across all 8 cycles.
- Top-level div8u4_seq holds the FSM, shift registers, counter and output registers.

## Test plan
- 225 / 15 with out_ready=1 → out_valid exactly 8 cycles after acceptance; quotient=15, remainder=0, div_by_zero=0; in_ready low for 9 cycles.
- 200 / 7, then 255 / 1, then 0 / 9 back-to-back with in_valid held high → results 28 r4, 255 r0, 0 r0; new acceptance only after each DONE handshake.
- 0xAB / 0 → quotient=8'hFF, remainder=4'hB, div_by_zero=1. The next request, 0x40 / 4, clears div_by_zero and gives 16 r0.
- 150 / 11 with out_ready low for 5 cycles after out_valid → outputs frozen at 13 r7, out_valid high throughout; IDLE one cycle after out_ready rises.
- rst_n pulsed low during iteration 4 of 99 / 5 → out_valid never asserts, all outputs 0, in_ready high. The next request, 99 / 5, gives 19 r4.
- Exhaustive sweep of all 4096 (dividend, divisor) pairs with random out_ready stalls, checked against a behavioural reference model. Also check the multiplier round-trip: for all a, b with b≠0, quotient==a and remainder==0 for dividend=a·b.
